// File: rtl/uart_byte_tx.sv
// rtl/uart_byte_tx.sv - 8N1/8N2 UART byte transmitter with one-byte holding register
// Holding register lets the next byte queue behind the shifter so frames go out back to back.
module uart_byte_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       rdy,
  output logic       tx,
  output logic       busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [7:0]    hold_q, hold_d;
  logic          hold_full_q, hold_full_d;
  logic [7:0]    shift_q, shift_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic          tx_q, tx_d;
  logic          accept, bit_end, load;

  assign accept  = data_valid & ~hold_full_q;
  assign bit_end = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      tx_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      tx_q        <= tx_d;
    end
  end

  // The stop phase reuses the bit index to count stop bits, keeping the baud counter narrow.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (hold_full_q) begin
          load    = 1'b1;
          state_d = START;
        end
      end
      START: if (bit_end) state_d = DATA;
      DATA:  if (bit_end && idx_q == 3'd7) state_d = STOP;
      STOP: begin
        if (bit_end && idx_q == STOP_LAST) begin
          if (hold_full_q) begin
            load    = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;

    if (state_q == IDLE || load || bit_end) cnt_d = '0;
    else                                    cnt_d = cnt_q + CW'(1);

    if (state_d != state_q)                                   idx_d = '0;
    else if (bit_end && (state_q == DATA || state_q == STOP)) idx_d = idx_q + 3'd1;

    if (load)                             shift_d = hold_q;
    else if (state_q == DATA && bit_end)  shift_d = {1'b0, shift_q[7:1]};

    if (accept) begin
      hold_d      = data_in;
      hold_full_d = 1'b1;
    end else if (load) begin
      hold_full_d = 1'b0;
    end
  end

  // tx is registered from the next state so the line level lines up with the state register.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  assign tx   = tx_q;
  assign rdy  = ~hold_full_q;
  assign busy = hold_full_q | (state_q != IDLE);

endmodule
